// File: rtl/fifo_wr_arbiter.sv
// Round-robin sequencer sharing the async FIFO write port among NUM_REQ frame sources.
// Each grant writes a whole 1- or 2-byte frame, low byte first, then pulses the source's ack.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]              req_len_i,
    output logic [NUM_REQ-1:0]              req_ack_o,
    input  logic                            fifo_full_i,
    output logic                            fifo_w_inc_o,
    output logic [DATA_WIDTH-1:0]           fifo_wr_data_o,
    output logic                            busy_o,
    output logic [ID_WIDTH-1:0]             grant_id_o
);

    localparam int FW = 2 * DATA_WIDTH;
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  len_q, len_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;

    logic                  found_hi_s;
    logic [ID_WIDTH-1:0]   id_hi_s, id_lo_s, pick_id_s;
    logic [FW-1:0]         pick_frame_s;
    logic                  pick_len_s;

    // Round-robin pick: lowest requester above last_grant, else lowest requester overall.
    always_comb begin
        found_hi_s = 1'b0;
        id_hi_s    = '0;
        id_lo_s    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            id_hi_s    = (req_i[i] && (ID_WIDTH'(i) > last_q)) ? ID_WIDTH'(i) : id_hi_s;
            found_hi_s = found_hi_s | (req_i[i] && (ID_WIDTH'(i) > last_q));
            id_lo_s    = req_i[i] ? ID_WIDTH'(i) : id_lo_s;
        end
        pick_id_s = found_hi_s ? id_hi_s : id_lo_s;
    end

    // Select the picked source's frame and length.
    always_comb begin
        pick_frame_s = '0;
        pick_len_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_frame_s = (ID_WIDTH'(i) == pick_id_s) ? req_data_i[i*FW +: FW] : pick_frame_s;
            pick_len_s   = (ID_WIDTH'(i) == pick_id_s) ? req_len_i[i] : pick_len_s;
        end
    end

    // Next-state logic; frame, length and grant are captured only at grant time.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        len_d   = len_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = SEND_LO;
                    frame_d = pick_frame_s;
                    len_d   = pick_len_s;
                    grant_d = pick_id_s;
                    last_d  = pick_id_s;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND_LO: begin
                if (!fifo_full_i) begin
                    state_d = len_q ? SEND_HI : ACK;
                end else begin
                    state_d = SEND_LO;
                end
            end
            SEND_HI: begin
                if (!fifo_full_i) begin
                    state_d = ACK;
                end else begin
                    state_d = SEND_HI;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output register inputs derived from the upcoming state so outputs track the state exactly.
    always_comb begin
        ack_d     = '0;
        busy_d    = (state_d != IDLE);
        wr_data_d = wr_data_q;
        case (state_d)
            SEND_LO: wr_data_d = frame_d[DATA_WIDTH-1:0];
            SEND_HI: wr_data_d = frame_d[FW-1:DATA_WIDTH];
            ACK:     ack_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_d;
            default: wr_data_d = wr_data_q;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            len_q     <= 1'b0;
            grant_q   <= '0;
            last_q    <= LAST_ID;
            ack_q     <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            len_q     <= len_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    // The strobe must react to FULL in the same cycle, so it stays combinational.
    assign fifo_w_inc_o   = rst_n_i & ((state_q == SEND_LO) | (state_q == SEND_HI)) & ~fifo_full_i;
    assign fifo_wr_data_o = wr_data_q;
    assign req_ack_o      = ack_q;
    assign busy_o         = busy_q;
    assign grant_id_o     = grant_q;

endmodule
